// File: rtl/four_way_round_robin_arbiter_if.sv
// Request/grant bundle between the requesters and the four-way round-robin arbiter.
// master = requester side (drives req), slave = arbiter side (drives grant/select/status).
interface four_way_round_robin_arbiter_if;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] select;
    logic       busy;
    logic       timeout;

    modport master (
        output req,
        input  grant,
        input  select,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        output grant,
        output select,
        output busy,
        output timeout
    );
endinterface

// File: rtl/four_way_round_robin_arbiter.sv
// Round-robin arbiter for four requesters; drives a one-hot grant and the mux select.
// Optional forced release after HOLD_MAX grant cycles when ARB_TIMEOUT_EN is defined.
module four_way_round_robin_arbiter #(
    parameter int unsigned HOLD_MAX = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    four_way_round_robin_arbiter_if.slave arb
);

    if ((2 ** CNT_W) < HOLD_MAX || HOLD_MAX == 0) begin : g_cfg_err
        $error("four_way_round_robin_arbiter: CNT_W too narrow for HOLD_MAX");
    end

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] select_q, select_d;
    logic       busy_q, busy_d;
    logic [1:0] last_q, last_d;

    logic       pick_valid;
    logic [1:0] pick_idx;
    logic       owner_req;
    logic       hold_expired;

    assign owner_req = arb.req[select_q];

    // Scan starts one past the last winner so the previous owner ranks lowest.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = last_q;
        for (int k = 1; k <= 4; k++) begin
            logic [1:0] cand;
            cand = last_q + 2'(k);
            if (!pick_valid && arb.req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    assign hold_expired = (cnt_q == CNT_W'(HOLD_MAX - 1));

    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        if (state_q == StIdle) begin
            if (pick_valid) begin
                cnt_d = '0;
            end
        end else begin
            // A dropped request on the final cycle is a normal release.
            if (owner_req && hold_expired) begin
                timeout_d = 1'b1;
            end
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign arb.timeout = timeout_q;
`else
    assign hold_expired = 1'b0;
    assign arb.timeout  = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        select_d = select_q;
        busy_d   = busy_q;
        last_d   = last_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d  = StGrant;
                    grant_d  = 4'b0001 << pick_idx;
                    select_d = pick_idx;
                    busy_d   = 1'b1;
                    last_d   = pick_idx;
                end
            end
            StGrant: begin
                // select is deliberately held through release.
                if (!owner_req || hold_expired) begin
                    state_d = StIdle;
                    grant_d = 4'b0000;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            grant_q  <= 4'b0000;
            select_q <= 2'b00;
            busy_q   <= 1'b0;
            last_q   <= 2'd3;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            select_q <= select_d;
            busy_q   <= busy_d;
            last_q   <= last_d;
        end
    end

    assign arb.grant  = grant_q;
    assign arb.select = select_q;
    assign arb.busy   = busy_q;

`ifndef SYNTHESIS
    a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(grant_q));
    a_busy_state : assert property (@(posedge clk) disable iff (!rst_n)
        busy_q == (state_q == StGrant));
    a_grant_select : assert property (@(posedge clk) disable iff (!rst_n)
        busy_q |-> (grant_q == (4'b0001 << select_q)));
`endif

endmodule

// File: tb/tb_four_way_round_robin_arbiter.sv
// Randomized self-checking bench for four_way_round_robin_arbiter against a behavioural model.
module tb_four_way_round_robin_arbiter;

    localparam int unsigned HOLD_MAX = 4;
    localparam int unsigned CNT_W    = 4;

    logic clk = 1'b0;
    logic rst_n;
    bit   clk_run;

    four_way_round_robin_arbiter_if arb_if ();

    four_way_round_robin_arbiter #(
        .HOLD_MAX (HOLD_MAX),
        .CNT_W    (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (arb_if)
    );

    initial begin
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    int n_tests;
    int n_fail;

    // Model: who owns the grant, who won last, and whether a forced release just happened.
    bit m_busy;
    int m_sel;
    int m_last;
    bit m_tmo;
`ifdef ARB_TIMEOUT_EN
    int m_held;
`endif

    function automatic void model_reset();
        m_busy = 1'b0;
        m_sel  = 0;
        m_last = 3;
        m_tmo  = 1'b0;
`ifdef ARB_TIMEOUT_EN
        m_held = 0;
`endif
    endfunction

    function automatic void model_edge(input logic [3:0] r);
        m_tmo = 1'b0;
        if (!m_busy) begin
            for (int k = 1; k <= 4; k++) begin
                int i;
                i = (m_last + k) % 4;
                if (r[i]) begin
                    m_busy = 1'b1;
                    m_sel  = i;
                    m_last = i;
`ifdef ARB_TIMEOUT_EN
                    m_held = 1;
`endif
                    break;
                end
            end
        end else if (!r[m_sel]) begin
            m_busy = 1'b0;
        end else begin
`ifdef ARB_TIMEOUT_EN
            if (m_held == int'(HOLD_MAX)) begin
                m_busy = 1'b0;
                m_tmo  = 1'b1;
            end else begin
                m_held++;
            end
`endif
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [3:0] eg;
        eg = m_busy ? 4'(1 << m_sel) : 4'b0000;
        check("grant", 32'(arb_if.grant), 32'(eg));
        check("select", 32'(arb_if.select), 32'(m_sel));
        check("busy", 32'(arb_if.busy), 32'(m_busy));
        check("timeout", 32'(arb_if.timeout), 32'(m_tmo));
    endtask

    task automatic step(input logic [3:0] r);
        arb_if.req = r;
        @(posedge clk);
        model_edge(r);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        logic [3:0] r;
        n_tests = 0;
        n_fail  = 0;
        model_reset();
        rst_n      = 1'b0;
        arb_if.req = 4'b0000;
        clk_run    = 1'b1;
        repeat (2) @(negedge clk);
        compare_all();
        check("rst_grant", 32'(arb_if.grant), 32'h0);
        check("rst_select", 32'(arb_if.select), 32'h0);
        rst_n = 1'b1;

        step(4'b0001);
        check("first_grant", 32'(arb_if.grant), 32'h1);
        repeat (3) step(4'b0001);

        // Async reset mid-grant with the clock parked low.
        clk_run = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_grant", 32'(arb_if.grant), 32'h0);
        check("arst_select", 32'(arb_if.select), 32'h0);
        check("arst_busy", 32'(arb_if.busy), 32'h0);
        check("arst_timeout", 32'(arb_if.timeout), 32'h0);
        #4 rst_n = 1'b1;
        arb_if.req = 4'b0001;
        #5 clk_run = 1'b1;
        step(4'b0001);
        check("post_rst_grant", 32'(arb_if.grant), 32'h1);
        step(4'b0000);

        step(4'b0010);
        check("grant_idx1", 32'(arb_if.grant), 32'h2);
        step(4'b0000);
        check("rel_grant", 32'(arb_if.grant), 32'h0);
        check("rel_busy", 32'(arb_if.busy), 32'h0);
        check("rel_select", 32'(arb_if.select), 32'h1);
        check("rel_timeout", 32'(arb_if.timeout), 32'h0);
        step(4'b1011);
        check("wrap_grant", 32'(arb_if.grant), 32'h8);
        check("wrap_select", 32'(arb_if.select), 32'h3);
        step(4'b0000);

`ifndef ARB_TIMEOUT_EN
        step(4'b0100);
        for (int c = 0; c < 100; c++) begin
            step(4'b0100);
            check("hold_grant", 32'(arb_if.grant), 32'h4);
            check("hold_busy", 32'(arb_if.busy), 32'h1);
        end
        step(4'b0000);
`else
        repeat (5 * (HOLD_MAX + 1)) step(4'b1111);
        step(4'b0000);
`endif

        for (int c = 0; c < 500; c++) begin
            r = 4'($urandom);
            if (m_busy && $urandom_range(0, 9) < 7) r[m_sel] = 1'b1;
            if ($urandom_range(0, 7) == 0) r = 4'b0000;
            step(r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
